fetch_pc_stage: RTL and testbench
=================================

# fetch_pc_stage

Instruction-fetch stage of the pipelined MIPS datapath: holds the program counter, selects the next PC, drives the instruction-memory address and latches the fetched word into the IF/ID pipeline register. It sits directly downstream of the branch-decision AND gate: it consumes `PCSrc` (`Branch & Zero`) together with the branch target from the later stage, plus jump and stall controls from decode and hazard logic.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; bits [1:0] must be 00.
- `WIDTH`, default 32: data and address width.

Ports:
- `Clk`, input, 1: single clock; all state updates on the rising edge.
- `Rst_n`, input, 1: reset, synchronous and active-low.
- `PCSrc`, input, 1: taken-branch select; this is the AND-gate output.
- `BranchTarget`, input, WIDTH: branch target address.
- `Jump`, input, 1: jump select.
- `JumpTarget`, input, WIDTH: jump target address.
- `Stall`, input, 1: hold request from the hazard unit.
- `InstrAddr`, output, WIDTH: instruction-memory address, equal to the current PC.
- `Instr`, input, WIDTH: instruction-memory read data; the memory reads combinationally from `InstrAddr`.
- `IFID_PC4`, output, WIDTH: PC+4 of the latched instruction.
- `IFID_Instr`, output, WIDTH: latched instruction.
- `IFID_Valid`, output, 1: latched instruction is real, not a bubble.
- `FetchCount`, output, 32: number of valid instructions latched into IF/ID since reset.

## Operation
- Redirect is `Jump | PCSrc`. Next-PC priority:
  1. `Jump` selects `JumpTarget`.
  2. Otherwise `PCSrc` selects `BranchTarget`.
  3. Otherwise `Stall` holds the PC.
  4. Otherwise the PC advances to PC+4.
- Target bits [1:0] are discarded and forced to 00, so the PC is always word-aligned.
- PC+4 uses modulo 2^WIDTH arithmetic: 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- IF/ID update per rising edge, when `Rst_n`=1:
  - Redirect (overrides `Stall`): flush. `IFID_Instr`=32'h0 (NOP), `IFID_PC4`=0, `IFID_Valid`=0.
  - `Stall` with no redirect: all IF/ID registers hold their values.
  - Otherwise: `IFID_Instr`<=`Instr`, `IFID_PC4`<=PC+4, `IFID_Valid`<=1.
- `FetchCount` increments by 1 exactly on edges where IF/ID loads a new valid instruction. It wraps modulo 2^32.
- Simultaneous `Jump` and `PCSrc`: the jump wins; a single flush occurs.
- Stall-only freezes the whole stage: the PC and all IF/ID registers stay frozen.

## Timing
- Reset, on any rising edge with `Rst_n`=0, regardless of other inputs, mid-operation included:
  - PC=`RESET_PC`, so `InstrAddr`=`RESET_PC`.
  - `IFID_Instr`=0, `IFID_PC4`=0, `IFID_Valid`=0, `FetchCount`=0.
- First edge with `Rst_n`=1 (no stall or redirect): IF/ID captures the word at `RESET_PC` with `Valid`=1, and the PC becomes `RESET_PC`+4.
- Fetch latency: address to IF/ID output is 1 cycle.
- Redirect: the target appears on `InstrAddr` 1 cycle after the redirect edge. The target instruction reaches IF/ID on the following edge, giving exactly one bubble from this stage.
- Redirect and `Stall` are sampled on the same edge. They must be driven from registered pipeline state; no combinational path from `IFID_*` back to these inputs.

## Structure
- Shared package `datapath_pkg`:
  - `NOP_INSTR` = 32'h0
  - `PC_INCR` = 4
  - next-PC select encoding (`NPC_SEQ`, `NPC_BRANCH`, `NPC_JUMP`, `NPC_HOLD`)
- One sub-module `pc_reg`: the WIDTH-bit register with load enable and synchronous active-low reset to `RESET_PC`.
- Next-PC mux, IF/ID register and counter live in `fetch_pc_stage`.

## Test plan
- Reset then free-run with a memory holding word i = 32'h1000_0000+i: `IFID_Instr` follows 32'h1000_0000, 32'h1000_0001, … one per cycle; `IFID_PC4`=4, 8, …; `FetchCount`=1, 2, 3, ….
- `PCSrc`=1 with `BranchTarget`=32'h0000_0043 at PC=32'h10:
  - next `InstrAddr`=32'h40;
  - IF/ID shows a bubble (`Valid`=0, `Instr`=0);
  - the following cycle shows the word at 32'h40 with `IFID_PC4`=32'h44;
  - `FetchCount` does not increment on the bubble.
- `Stall` held 3 cycles: `InstrAddr`, `IFID_*` and `FetchCount` are unchanged for 3 edges, then resume. `Stall`+`PCSrc` together: the branch is taken and IF/ID is flushed.
- `Jump`=1 (`JumpTarget`=32'h200) with `PCSrc`=1 (`BranchTarget`=32'h100) on the same edge: `InstrAddr`=32'h200 and a single bubble.
- Mid-run reset:
  - drive `Rst_n`=0 for one edge while `PCSrc`=1 → PC=`RESET_PC`, `IFID_Valid`=0, `FetchCount`=0;
  - with `RESET_PC`=32'hFFFF_FFFC, after release, `InstrAddr` goes 32'hFFFF_FFFC, then 32'h0000_0000.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared datapath definitions: NOP encoding, PC increment and the
// next-PC select encoding used by the fetch stage.
package datapath_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int unsigned PC_INCR   = 32'd4;

    typedef enum logic [1:0] {
        NPC_SEQ    = 2'd0,
        NPC_BRANCH = 2'd1,
        NPC_JUMP   = 2'd2,
        NPC_HOLD   = 2'd3
    } npc_sel_e;

    // Next-PC priority: jump, then taken branch, then stall, then sequential.
    function automatic npc_sel_e npc_select(
        input logic jump,
        input logic pcsrc,
        input logic stall
    );
        npc_sel_e sel;
        if (jump) begin
            sel = NPC_JUMP;
        end else if (pcsrc) begin
            sel = NPC_BRANCH;
        end else if (stall) begin
            sel = NPC_HOLD;
        end else begin
            sel = NPC_SEQ;
        end
        return sel;
    endfunction

endpackage

// File: rtl/fetch_pc_stage_pc_reg.sv
// Program-counter register: load enable, synchronous active-low reset
// to a parameterised reset address.
module pc_reg #(
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0]  RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] pc_q;

    // PC state: reset wins, otherwise load only when enabled.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pc_q <= RESET_VAL;
        end else if (en_i) begin
            pc_q <= d_i;
        end else begin
            pc_q <= pc_q;
        end
    end

    assign q_o = pc_q;

endmodule

// File: rtl/fetch_pc_stage.sv
// Instruction-fetch stage: next-PC selection, PC register, IF/ID
// pipeline register and a count of valid instructions fetched.
module fetch_pc_stage
    import datapath_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}}
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             PCSrc,
    input  logic [WIDTH-1:0] BranchTarget,
    input  logic             Jump,
    input  logic [WIDTH-1:0] JumpTarget,
    input  logic             Stall,
    output logic [WIDTH-1:0] InstrAddr,
    input  logic [WIDTH-1:0] Instr,
    output logic [WIDTH-1:0] IFID_PC4,
    output logic [WIDTH-1:0] IFID_Instr,
    output logic             IFID_Valid,
    output logic [31:0]      FetchCount
);

    // Clears the two low bits so every loaded target is word-aligned.
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~{{(WIDTH-2){1'b0}}, 2'b11};

    npc_sel_e         npc_sel_s;
    logic [WIDTH-1:0] pc_s;
    logic [WIDTH-1:0] pc4_s;
    logic [WIDTH-1:0] pc_d;
    logic             pc_en_s;

    logic [WIDTH-1:0] ifid_pc4_q;
    logic [WIDTH-1:0] ifid_instr_q;
    logic             ifid_valid_q;
    logic [31:0]      fetch_count_q;

    assign npc_sel_s = npc_select(Jump, PCSrc, Stall);
    // Sequential address wraps naturally at 2^WIDTH.
    assign pc4_s     = pc_s + WIDTH'(PC_INCR);

    // Next-PC mux and PC load enable.
    always_comb begin
        pc_d    = pc_s;
        pc_en_s = 1'b0;
        case (npc_sel_s)
            NPC_JUMP: begin
                pc_d    = JumpTarget & ALIGN_MASK;
                pc_en_s = 1'b1;
            end
            NPC_BRANCH: begin
                pc_d    = BranchTarget & ALIGN_MASK;
                pc_en_s = 1'b1;
            end
            NPC_HOLD: begin
                pc_d    = pc_s;
                pc_en_s = 1'b0;
            end
            NPC_SEQ: begin
                pc_d    = pc4_s;
                pc_en_s = 1'b1;
            end
            default: begin
                pc_d    = pc_s;
                pc_en_s = 1'b0;
            end
        endcase
    end

    pc_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .clk_i  (Clk),
        .rst_ni (Rst_n),
        .en_i   (pc_en_s),
        .d_i    (pc_d),
        .q_o    (pc_s)
    );

    // IF/ID register and fetch counter: flush on redirect, freeze on stall,
    // otherwise capture the word at the current PC.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            ifid_pc4_q    <= {WIDTH{1'b0}};
            ifid_instr_q  <= WIDTH'(NOP_INSTR);
            ifid_valid_q  <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            case (npc_sel_s)
                NPC_JUMP, NPC_BRANCH: begin
                    ifid_pc4_q    <= {WIDTH{1'b0}};
                    ifid_instr_q  <= WIDTH'(NOP_INSTR);
                    ifid_valid_q  <= 1'b0;
                    fetch_count_q <= fetch_count_q;
                end
                NPC_HOLD: begin
                    ifid_pc4_q    <= ifid_pc4_q;
                    ifid_instr_q  <= ifid_instr_q;
                    ifid_valid_q  <= ifid_valid_q;
                    fetch_count_q <= fetch_count_q;
                end
                NPC_SEQ: begin
                    ifid_pc4_q    <= pc4_s;
                    ifid_instr_q  <= Instr;
                    ifid_valid_q  <= 1'b1;
                    fetch_count_q <= fetch_count_q + 32'd1;
                end
                default: begin
                    ifid_pc4_q    <= ifid_pc4_q;
                    ifid_instr_q  <= ifid_instr_q;
                    ifid_valid_q  <= ifid_valid_q;
                    fetch_count_q <= fetch_count_q;
                end
            endcase
        end
    end

    assign InstrAddr  = pc_s;
    assign IFID_PC4   = ifid_pc4_q;
    assign IFID_Instr = ifid_instr_q;
    assign IFID_Valid = ifid_valid_q;
    assign FetchCount = fetch_count_q;

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Bench for fetch_pc_stage: two instances (reset PC 0 and 0xFFFF_FFFC)
// share stimulus; a behavioural model of the stage is checked every cycle,
// and directed phases pin literal values from the fetch rules.
module tb_fetch_pc_stage;

    logic        clk;
    logic        rst_n;
    logic        pcsrc;
    logic        jump;
    logic        stall;
    logic [31:0] btgt;
    logic [31:0] jtgt;

    logic [31:0] addr_a, instr_a, pc4_a, ifi_a, cnt_a;
    logic        val_a;
    logic [31:0] addr_b, instr_b, pc4_b, ifi_b, cnt_b;
    logic        val_b;

    int total;
    int bad;

    // Memory word i holds 32'h1000_0000 + i.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    assign instr_a = mem_word(addr_a);
    assign instr_b = mem_word(addr_b);

    fetch_pc_stage #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut_a (
        .Clk(clk), .Rst_n(rst_n), .PCSrc(pcsrc), .BranchTarget(btgt),
        .Jump(jump), .JumpTarget(jtgt), .Stall(stall),
        .InstrAddr(addr_a), .Instr(instr_a), .IFID_PC4(pc4_a),
        .IFID_Instr(ifi_a), .IFID_Valid(val_a), .FetchCount(cnt_a)
    );

    fetch_pc_stage #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_b (
        .Clk(clk), .Rst_n(rst_n), .PCSrc(pcsrc), .BranchTarget(btgt),
        .Jump(jump), .JumpTarget(jtgt), .Stall(stall),
        .InstrAddr(addr_b), .Instr(instr_b), .IFID_PC4(pc4_b),
        .IFID_Instr(ifi_b), .IFID_Valid(val_b), .FetchCount(cnt_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model state, index 0 = instance a, 1 = instance b.
    logic [31:0] m_pc    [2];
    logic [31:0] m_instr [2];
    logic [31:0] m_pc4   [2];
    logic [31:0] m_cnt   [2];
    logic        m_val   [2];
    logic [31:0] m_rst   [2];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // One rising edge of the stage as described by its fetch rules.
    task automatic model_edge(input int k);
        logic [31:0] t;
        if (!rst_n) begin
            m_pc[k] = m_rst[k]; m_instr[k] = 32'h0; m_pc4[k] = 32'h0;
            m_val[k] = 1'b0;    m_cnt[k] = 32'h0;
        end else if (jump || pcsrc) begin
            t = jump ? jtgt : btgt;
            m_pc[k] = {t[31:2], 2'b00};
            m_instr[k] = 32'h0; m_pc4[k] = 32'h0; m_val[k] = 1'b0;
        end else if (!stall) begin
            m_instr[k] = mem_word(m_pc[k]);
            m_pc4[k]   = m_pc[k] + 32'd4;
            m_val[k]   = 1'b1;
            m_cnt[k]   = m_cnt[k] + 32'd1;
            m_pc[k]    = m_pc[k] + 32'd4;
        end
    endtask

    // Advance one clock, update the model, then compare both instances.
    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check("a_addr",  addr_a, m_pc[0]);
        check("a_instr", ifi_a,  m_instr[0]);
        check("a_pc4",   pc4_a,  m_pc4[0]);
        check("a_valid", {31'd0, val_a}, {31'd0, m_val[0]});
        check("a_count", cnt_a,  m_cnt[0]);
        check("b_addr",  addr_b, m_pc[1]);
        check("b_instr", ifi_b,  m_instr[1]);
        check("b_pc4",   pc4_b,  m_pc4[1]);
        check("b_valid", {31'd0, val_b}, {31'd0, m_val[1]});
        check("b_count", cnt_b,  m_cnt[1]);
    endtask

    task automatic drive(input logic r, input logic ps, input logic [31:0] bt,
                         input logic j, input logic [31:0] jt, input logic st);
        rst_n = r; pcsrc = ps; btgt = bt; jump = j; jtgt = jt; stall = st;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        m_rst[0] = 32'h0000_0000;
        m_rst[1] = 32'hFFFF_FFFC;
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = 32'h0; m_instr[k] = 32'h0; m_pc4[k] = 32'h0;
            m_val[k] = 1'b0; m_cnt[k] = 32'h0;
        end

        // Reset with noisy controls.
        drive(1'b0, 1'b1, 32'h0000_0123, 1'b1, 32'h0000_0456, 1'b1);
        step();
        step();
        check("rst_addr_a",  addr_a, 32'h0000_0000);
        check("rst_addr_b",  addr_b, 32'hFFFF_FFFC);
        check("rst_valid_a", {31'd0, val_a}, 32'd0);
        check("rst_count_a", cnt_a, 32'd0);

        // Free run: one word per cycle.
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            step();
            check("run_instr", ifi_a, 32'h1000_0000 + 32'(k - 1));
            check("run_pc4",   pc4_a, 32'(4 * k));
            check("run_count", cnt_a, 32'(k));
        end
        check("run_addr", addr_a, 32'h0000_0010);

        // Taken branch with misaligned target at PC=0x10.
        drive(1'b1, 1'b1, 32'h0000_0043, 1'b0, 32'h0, 1'b0);
        step();
        check("br_addr",   addr_a, 32'h0000_0040);
        check("br_valid",  {31'd0, val_a}, 32'd0);
        check("br_instr",  ifi_a, 32'h0000_0000);
        check("br_count",  cnt_a, 32'd4);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step();
        check("br_tgt_instr", ifi_a, 32'h1000_0010);
        check("br_tgt_pc4",   pc4_a, 32'h0000_0044);
        check("br_tgt_count", cnt_a, 32'd5);

        // Three-cycle stall freezes the stage.
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_addr",  addr_a, 32'h0000_0044);
            check("stall_instr", ifi_a,  32'h1000_0010);
            check("stall_count", cnt_a,  32'd5);
        end
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step();
        check("resume_instr", ifi_a, 32'h1000_0011);
        check("resume_count", cnt_a, 32'd6);

        // Stall together with branch: branch taken, flush.
        drive(1'b1, 1'b1, 32'h0000_0080, 1'b0, 32'h0, 1'b1);
        step();
        check("stbr_addr",  addr_a, 32'h0000_0080);
        check("stbr_valid", {31'd0, val_a}, 32'd0);

        // Jump and branch together: jump wins.
        drive(1'b1, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0200, 1'b0);
        step();
        check("jb_addr",  addr_a, 32'h0000_0200);
        check("jb_valid", {31'd0, val_a}, 32'd0);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step();
        check("jb_instr", ifi_a, 32'h1000_0080);
        check("jb_count", cnt_a, 32'd7);

        // Mid-run reset while a branch is requested.
        drive(1'b0, 1'b1, 32'h0000_0300, 1'b0, 32'h0, 1'b0);
        step();
        check("mrst_addr_a",  addr_a, 32'h0000_0000);
        check("mrst_valid_a", {31'd0, val_a}, 32'd0);
        check("mrst_count_a", cnt_a, 32'd0);
        check("mrst_addr_b",  addr_b, 32'hFFFF_FFFC);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step();
        check("wrap_addr_b",  addr_b, 32'h0000_0000);
        check("wrap_instr_b", ifi_b,  32'h4FFF_FFFF);
        check("wrap_pc4_b",   pc4_b,  32'h0000_0000);
        check("wrap_addr_a",  addr_a, 32'h0000_0004);

        // Randomised control traffic against the model.
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 49) != 0),
                  ($urandom_range(0, 7) == 0), $urandom(),
                  ($urandom_range(0, 11) == 0), $urandom(),
                  ($urandom_range(0, 3) == 0));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
